// File: rtl/sprite_ctrl_pkg.sv
// Shared register map and bit positions for the sprite controller.
package sprite_ctrl_pkg;

  typedef enum logic [2:0] {
    REG_SPRX   = 3'd0,
    REG_SPRY   = 3'd1,
    REG_PERIOD = 3'd2,
    REG_SEQ    = 3'd3,
    REG_CTRL   = 3'd4,
    REG_STATUS = 3'd5
  } reg_addr_e;

  localparam int CTRL_VIS_BIT   = 0;
  localparam int CTRL_RUN_BIT   = 1;
  localparam int CTRL_MOVE_BIT  = 2;
  localparam int STAT_FRAME_BIT = 0;
  localparam int STAT_PEND_BIT  = 1;

  localparam int SEQ_ENTRY_W  = 2;
  localparam int SEQ_ENTRIES  = 4;
  localparam int PERIOD_W     = 6;

  typedef struct packed {
    logic move;
    logic run;
    logic vis;
  } ctrl_t;

endpackage

// File: rtl/sprite_ctrl_anim_seq.sv
// Animation sequencer: steps through the 4-entry frame list every PERIOD
// frames and latches the ROM base of the selected graphic at each frame.
module sprite_ctrl_anim_seq
  import sprite_ctrl_pkg::*;
#(
  parameter int ADDRW      = 12,
  parameter int SPR_PIXELS = 640,
  parameter int SPR_FRAMES = 3
) (
  input  logic                                 clk_pix,
  input  logic                                 reset,
  input  logic                                 frame,
  input  logic                                 run,
  input  logic [PERIOD_W-1:0]                  period,
  input  logic                                 period_wr,
  input  logic [SEQ_ENTRIES*SEQ_ENTRY_W-1:0]   seq,
  output logic [ADDRW-1:0]                     spr_base_addr
);

  if (SPR_FRAMES * SPR_PIXELS > (1 << ADDRW)) begin : g_bad_rom_size
    $error("sprite ROM does not fit in ADDRW address bits");
  end

  logic [PERIOD_W-1:0]    cnt, cnt_nxt;
  logic [1:0]             idx, idx_nxt;
  logic [SEQ_ENTRY_W-1:0] entry;
  logic [ADDRW-1:0]       base_nxt;

  always_comb begin
    cnt_nxt = cnt;
    idx_nxt = idx;
    if (run && period != '0) begin
      if (cnt == period - PERIOD_W'(1)) begin
        cnt_nxt = '0;
        idx_nxt = idx + 2'd1;
      end else begin
        cnt_nxt = cnt + PERIOD_W'(1);
      end
    end
  end

  // Base is decoded from the index that becomes current at this frame, so
  // the address is registered together with idx and holds for the frame.
  always_comb begin
    entry    = seq[{idx_nxt, 1'b0} +: SEQ_ENTRY_W];
    base_nxt = '0;
    if (int'(entry) < SPR_FRAMES)
      base_nxt = ADDRW'(entry) * ADDRW'(SPR_PIXELS);
  end

  always_ff @(posedge clk_pix or posedge reset) begin
    if (reset) begin
      cnt           <= '0;
      idx           <= '0;
      spr_base_addr <= '0;
    end else begin
      if (frame) begin
        idx           <= idx_nxt;
        spr_base_addr <= base_nxt;
      end
      if (period_wr)
        cnt <= '0;
      else if (frame)
        cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/sprite_ctrl.sv
// Sprite controller: CPU shadow registers committed at frame boundaries,
// animation sequencing and sticky frame flag. Option: SPRITE_CTRL_AUTOMOVE_EN.
module sprite_ctrl
  import sprite_ctrl_pkg::*;
#(
  parameter int CORDW      = 16,
  parameter int ADDRW      = 12,
  parameter int SPR_PIXELS = 640,
  parameter int SPR_FRAMES = 3,
  parameter int H_RES      = 640,
  parameter int SPR_W_PIX  = 128,
  parameter int SPEED_X    = 2
) (
  input  logic                    clk_pix,
  input  logic                    reset,
  input  logic                    frame,
  input  logic                    wr_en,
  input  logic                    rd_en,
  input  logic [2:0]              reg_addr,
  input  logic [15:0]             wr_data,
  output logic [15:0]             rd_data,
  output logic signed [CORDW-1:0] sprx,
  output logic signed [CORDW-1:0] spry,
  output logic                    spr_en,
  output logic [ADDRW-1:0]        spr_base_addr,
  output logic                    frame_irq
);

  if (SPEED_X >= H_RES || SPR_W_PIX <= 0) begin : g_bad_move_cfg
    $error("auto-move step/wrap parameters are inconsistent");
  end

  logic [CORDW-1:0]    sprx_sh, spry_sh;
  ctrl_t               ctrl_sh;
  logic                pending;
  logic [PERIOD_W-1:0] period;
  logic [7:0]          seq;
  logic                run_act;
  logic                frame_flag;
  logic [15:0]         rd_mux;

  logic wr_shadow, wr_period, rd_status, commit;

  assign wr_shadow = wr_en && (reg_addr == REG_SPRX || reg_addr == REG_SPRY ||
                               reg_addr == REG_CTRL);
  assign wr_period = wr_en && reg_addr == REG_PERIOD;
  assign rd_status = rd_en && reg_addr == REG_STATUS;
  assign commit    = frame && pending;
  assign frame_irq = frame_flag;

`ifdef SPRITE_CTRL_AUTOMOVE_EN
  localparam logic signed [CORDW-1:0] MV_STEP = CORDW'(SPEED_X);
  localparam logic signed [CORDW-1:0] MV_WRAP = CORDW'(H_RES);
  localparam logic signed [CORDW-1:0] MV_HOME = CORDW'(-SPR_W_PIX);

  logic                    move_act;
  logic signed [CORDW-1:0] sprx_step, sprx_mv;

  assign sprx_step = sprx + MV_STEP;
  assign sprx_mv   = (sprx_step >= MV_WRAP) ? MV_HOME : sprx_step;
`endif

  // CPU register writes; PERIOD/SEQ are live, the rest only reach the shadow.
  always_ff @(posedge clk_pix or posedge reset) begin
    if (reset) begin
      sprx_sh <= '0;
      spry_sh <= '0;
      ctrl_sh <= '0;
      period  <= '0;
      seq     <= '0;
    end else if (wr_en) begin
      case (reg_addr_e'(reg_addr))
        REG_SPRX:   sprx_sh <= CORDW'(wr_data);
        REG_SPRY:   spry_sh <= CORDW'(wr_data);
        REG_PERIOD: period  <= wr_data[PERIOD_W-1:0];
        REG_SEQ:    seq     <= wr_data[7:0];
        REG_CTRL: begin
          ctrl_sh.vis  <= wr_data[CTRL_VIS_BIT];
          ctrl_sh.run  <= wr_data[CTRL_RUN_BIT];
`ifdef SPRITE_CTRL_AUTOMOVE_EN
          ctrl_sh.move <= wr_data[CTRL_MOVE_BIT];
`else
          ctrl_sh.move <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

  // A write landing on the commit frame keeps pending set for the next frame.
  always_ff @(posedge clk_pix or posedge reset) begin
    if (reset)
      pending <= 1'b0;
    else if (wr_shadow)
      pending <= 1'b1;
    else if (frame)
      pending <= 1'b0;
  end

  always_ff @(posedge clk_pix or posedge reset) begin
    if (reset) begin
      sprx     <= '0;
      spry     <= '0;
      spr_en   <= 1'b0;
      run_act  <= 1'b0;
`ifdef SPRITE_CTRL_AUTOMOVE_EN
      move_act <= 1'b0;
`endif
    end else if (commit) begin
      sprx     <= sprx_sh;
      spry     <= spry_sh;
      spr_en   <= ctrl_sh.vis;
      run_act  <= ctrl_sh.run;
`ifdef SPRITE_CTRL_AUTOMOVE_EN
      move_act <= ctrl_sh.move;
    end else if (frame && move_act) begin
      sprx     <= sprx_mv;
`endif
    end
  end

  // Frame set has priority over the read-to-clear.
  always_ff @(posedge clk_pix or posedge reset) begin
    if (reset)
      frame_flag <= 1'b0;
    else if (frame)
      frame_flag <= 1'b1;
    else if (rd_status)
      frame_flag <= 1'b0;
  end

  always_comb begin
    rd_mux = '0;
    case (reg_addr_e'(reg_addr))
      REG_SPRX:   rd_mux = 16'(sprx_sh);
      REG_SPRY:   rd_mux = 16'(spry_sh);
      REG_PERIOD: rd_mux = 16'(period);
      REG_SEQ:    rd_mux = 16'(seq);
      REG_CTRL:   rd_mux = 16'(ctrl_sh);
      REG_STATUS: begin
        rd_mux[STAT_FRAME_BIT] = frame_flag;
        rd_mux[STAT_PEND_BIT]  = pending;
      end
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_pix or posedge reset) begin
    if (reset)
      rd_data <= '0;
    else if (rd_en)
      rd_data <= rd_mux;
  end

  sprite_ctrl_anim_seq #(
    .ADDRW      (ADDRW),
    .SPR_PIXELS (SPR_PIXELS),
    .SPR_FRAMES (SPR_FRAMES)
  ) u_anim_seq (
    .clk_pix       (clk_pix),
    .reset         (reset),
    .frame         (frame),
    .run           (run_act),
    .period        (period),
    .period_wr     (wr_period),
    .seq           (seq),
    .spr_base_addr (spr_base_addr)
  );

endmodule
